// File: rtl/hazard3_shift_pkg.sv
// hazard3_shift_pkg: shared shifter op bit positions, legal op encodings and source tags
package hazard3_shift_pkg;
   localparam int SHIFT_OP_RNL   = 0;
   localparam int SHIFT_OP_ARITH = 1;
   localparam int SHIFT_OP_ROT   = 2;
   localparam logic [2:0] SHIFT_OP_SLL = 3'b000;
   localparam logic [2:0] SHIFT_OP_SRL = 3'b001;
   localparam logic [2:0] SHIFT_OP_SRA = 3'b011;
   localparam logic [2:0] SHIFT_OP_ROL = 3'b100;
   localparam logic [2:0] SHIFT_OP_ROR = 3'b101;
   localparam logic SHIFT_SRC_A = 1'b0;
   localparam logic SHIFT_SRC_B = 1'b1;
   function automatic logic shift_op_legal(input logic [2:0] op);
      return op inside {SHIFT_OP_SLL, SHIFT_OP_SRL, SHIFT_OP_SRA, SHIFT_OP_ROL, SHIFT_OP_ROR};
   endfunction
endpackage

// File: rtl/hazard3_shift_barrel.sv
// hazard3_shift_barrel: combinational right shifter/rotator; left ops bit-reverse in and out.
module hazard3_shift_barrel import hazard3_shift_pkg::*; #(
   parameter int W_DATA        = 32,
   parameter int W_SHAMT       = 5,
   parameter int EXTENSION_ZBB = 0
) (
   input  logic [W_DATA-1:0]  din,
   input  logic [W_SHAMT-1:0] shamt,
   input  logic [2:0]         op,
   output logic [W_DATA-1:0]  dout
);
   logic right, rot, fill;
   logic [W_DATA-1:0] din_r, acc;
   assign right = op[SHIFT_OP_RNL];
   assign rot   = (EXTENSION_ZBB != 0) && op[SHIFT_OP_ROT];
   assign fill  = !rot && right && op[SHIFT_OP_ARITH] && din[W_DATA-1];
   always_comb begin
      for (int i = 0; i < W_DATA; i++) din_r[i] = right ? din[i] : din[W_DATA-1-i];
      acc = din_r;
      for (int i = 0; i < W_SHAMT; i++)
         if (shamt[i]) acc = (acc >> (1 << i)) | (rot ? acc << (W_DATA - (1 << i)) : (fill ? ~({W_DATA{1'b1}} >> (1 << i)) : '0));
      for (int i = 0; i < W_DATA; i++) dout[i] = right ? acc[i] : acc[W_DATA-1-i];
   end
endmodule

// File: rtl/hazard3_shift_sched.sv
// hazard3_shift_sched: two-port arbiter over one shared barrel shifter with a tagged result register.
// HAZARD3_SHIFT_SCHED_RR_EN selects round-robin (else A has fixed priority); HAZARD3_ASSERTIONS adds protocol checks.
module hazard3_shift_sched import hazard3_shift_pkg::*; #(
   parameter int W_DATA        = 32,
   parameter int W_SHAMT       = 5,
   parameter int EXTENSION_ZBB = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               a_valid,
   output logic               a_ready,
   input  logic [W_DATA-1:0]  a_din,
   input  logic [W_SHAMT-1:0] a_shamt,
   input  logic [2:0]         a_op,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [W_DATA-1:0]  b_din,
   input  logic [W_SHAMT-1:0] b_shamt,
   input  logic [2:0]         b_op,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_src,
   output logic [W_DATA-1:0]  rsp_data
);
   logic can_acc, pri_a, grant_b, xfer;
   logic [W_DATA-1:0] sh_din, sh_dout;
   logic [W_SHAMT-1:0] sh_shamt;
   logic [2:0] sh_op;
`ifdef HAZARD3_SHIFT_SCHED_RR_EN
   logic ptr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= SHIFT_SRC_A;
      else if (xfer) ptr <= grant_b ? SHIFT_SRC_A : SHIFT_SRC_B;
   assign pri_a = ptr == SHIFT_SRC_A;
`else
   assign pri_a = 1'b1;
`endif
   // A port's ready only looks at whether the other port would beat it, never at its own valid
   assign can_acc = rst_n && (!rsp_valid || rsp_ready);
   assign a_ready = can_acc && !(b_valid && !pri_a);
   assign b_ready = can_acc && !(a_valid && pri_a);
   assign grant_b = b_valid && !(a_valid && pri_a);
   assign xfer    = (a_valid && a_ready) || (b_valid && b_ready);
   assign sh_din   = grant_b ? b_din : a_din;
   assign sh_shamt = grant_b ? b_shamt : a_shamt;
   assign sh_op    = grant_b ? b_op : a_op;
   hazard3_shift_barrel #(
      .W_DATA(W_DATA),
      .W_SHAMT(W_SHAMT),
      .EXTENSION_ZBB(EXTENSION_ZBB)
   ) shifter (
      .din(sh_din),
      .shamt(sh_shamt),
      .op(sh_op),
      .dout(sh_dout)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_src   <= SHIFT_SRC_A;
         rsp_data  <= '0;
      end else if (xfer) begin
         rsp_valid <= 1'b1;
         rsp_src   <= grant_b ? SHIFT_SRC_B : SHIFT_SRC_A;
         rsp_data  <= sh_dout;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
`ifdef HAZARD3_ASSERTIONS
   assert property (@(posedge clk) disable iff (!rst_n) a_valid && !a_ready |=> a_valid && $stable({a_din, a_shamt, a_op}));
   assert property (@(posedge clk) disable iff (!rst_n) b_valid && !b_ready |=> b_valid && $stable({b_din, b_shamt, b_op}));
   assert property (@(posedge clk) disable iff (!rst_n) a_valid |-> shift_op_legal(a_op));
   assert property (@(posedge clk) disable iff (!rst_n) b_valid |-> shift_op_legal(b_op));
`endif
endmodule
